// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Arbitrates a single-port data SRAM between the pipeline
//                Memory stage (core) and an external loader/debug port (ext).
//                Core has fixed priority, but once ext has waited STARVE_LIMIT
//                consecutive cycles it wins the next cycle. At most one access
//                is issued per cycle; read data is returned one cycle after
//                issue to the requester that issued it.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                core_memread/memwrite - core request (both high = write)
//                core_addr/core_wdata  - core byte address / write data
//                core_stall            - core request present but not granted
//                core_rdata/core_rvalid- core read return
//                ext_req/ext_we        - ext request (held until ext_gnt)
//                ext_addr/ext_wdata    - ext byte address / write data
//                ext_gnt               - ext request accepted this cycle
//                ext_rdata/ext_rvalid  - ext read return
//                mem_en/we/addr/wdata  - SRAM access (word address)
//                mem_rdata             - SRAM read data, one cycle after issue
//                err_flag              - sticky bad-address flag (option only)
//  Option      : DMEM_ARB_ERRCHK_EN - suppress misaligned / out-of-range
//                accesses and add the err_flag output.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_memread,
    input  logic              core_memwrite,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_stall,
    output logic [31:0]       core_rdata,
    output logic              core_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic [31:0]       ext_rdata,
    output logic              ext_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
`ifdef DMEM_ARB_ERRCHK_EN
    output logic              err_flag,
`endif
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic        w_core_req;
    logic        w_ext_override;
    logic        w_ext_win;
    logic        w_core_win;
    logic        w_any_win;
    logic        w_sel_we;
    logic        w_sel_rd;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_suppress;

    logic [3:0]  r_starve_cnt;
    logic        r_rd_pending_core;
    logic        r_rd_pending_ext;
    logic        r_rd_zero;

    assign w_core_req     = core_memread | core_memwrite;
    assign w_ext_override = ext_req && (r_starve_cnt == C_STARVE_LIMIT);

    // Nothing is granted while reset is held.
    assign w_ext_win  = !reset && ext_req && (!w_core_req || w_ext_override);
    assign w_core_win = !reset && w_core_req && !w_ext_win;
    assign w_any_win  = w_ext_win | w_core_win;

    assign core_stall = !reset && w_core_req && !w_core_win;
    assign ext_gnt    = w_ext_win;

    // Winner select. A core request with both read and write high is a write.
    always_comb begin
        w_sel_addr  = 32'd0;
        w_sel_wdata = 32'd0;
        w_sel_we    = 1'b0;
        w_sel_rd    = 1'b0;
        if (w_ext_win) begin
            w_sel_addr  = ext_addr;
            w_sel_wdata = ext_wdata;
            w_sel_we    = ext_we;
            w_sel_rd    = !ext_we;
        end else if (w_core_win) begin
            w_sel_addr  = core_addr;
            w_sel_wdata = core_wdata;
            w_sel_we    = core_memwrite;
            w_sel_rd    = core_memread && !core_memwrite;
        end
    end

`ifdef DMEM_ARB_ERRCHK_EN
    logic w_addr_bad;
    logic r_err_flag;

    assign w_addr_bad = (w_sel_addr[1:0] != 2'b00) ||
                        ((w_sel_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_suppress = w_any_win && w_addr_bad;
    assign err_flag   = r_err_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_flag <= 1'b0;
        end else if (w_suppress) begin
            r_err_flag <= 1'b1;
        end
    end
`else
    logic w_unused_addr_bits;

    // Address bits outside the word index are intentionally ignored.
    assign w_unused_addr_bits = ^w_sel_addr;
    assign w_suppress         = 1'b0;
`endif

    // A suppressed access still completes its grant but never reaches the SRAM.
    assign mem_en    = w_any_win && !w_suppress;
    assign mem_we    = mem_en && w_sel_we;
    assign mem_addr  = mem_en ? w_sel_addr[ADDR_W+1:2] : '0;
    assign mem_wdata = mem_en ? w_sel_wdata : 32'd0;

    // Ext wait counter; saturates so the override stays asserted until served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!ext_req || w_ext_win) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != C_STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Owner tag for the read issued this cycle; data returns next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pending_core <= 1'b0;
            r_rd_pending_ext  <= 1'b0;
            r_rd_zero         <= 1'b0;
        end else begin
            r_rd_pending_core <= w_core_win && w_sel_rd;
            r_rd_pending_ext  <= w_ext_win && w_sel_rd;
            r_rd_zero         <= w_suppress;
        end
    end

    // Gating with reset drops a return whose issue preceded a reset assertion.
    assign core_rvalid = r_rd_pending_core && !reset;
    assign ext_rvalid  = r_rd_pending_ext && !reset;
    assign core_rdata  = (core_rvalid && !r_rd_zero) ? mem_rdata : 32'd0;
    assign ext_rdata   = (ext_rvalid && !r_rd_zero) ? mem_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Drives directed and
//                random traffic, models the SRAM, and compares every cycle
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int LIMIT  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_memread, core_memwrite;
    logic [31:0] core_addr, core_wdata;
    logic        core_stall, core_rvalid;
    logic [31:0] core_rdata;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_ERRCHK_EN
    logic        err_flag;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .reset(reset),
        .core_memread(core_memread), .core_memwrite(core_memwrite),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_ERRCHK_EN
        .err_flag(err_flag),
`endif
        .mem_rdata(mem_rdata)
    );

    // SRAM: synchronous read; noise on the data bus when no read was issued.
    logic [31:0] sram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
        else                   mem_rdata <= $urandom;
    end

    // Reference model state
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
    int          waited;        // consecutive cycles ext has been refused
    bit          pend_core, pend_ext;
    logic [31:0] pend_data;
    bit          err_exp;
    bit          last_stall, last_ext_wait, obs_gnt;
    int          n_total, n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check all outputs, advance the model.
    task automatic cyc(input bit rst, input bit crd, input bit cwr,
                       input logic [31:0] ca, input logic [31:0] cwd,
                       input bit er, input bit ewe,
                       input logic [31:0] ea, input logic [31:0] ewd);
        bit ecv, eev, creq, ewin, cwin, we, isrd, bad, issue;
        logic [31:0] a, wd;
        int word;
        @(negedge clk);
        reset = rst; core_memread = crd; core_memwrite = cwr;
        core_addr = ca; core_wdata = cwd;
        ext_req = er; ext_we = ewe; ext_addr = ea; ext_wdata = ewd;
        #1;
        ecv = pend_core && !rst;
        eev = pend_ext && !rst;
        chk("core_rvalid", core_rvalid, 32'(ecv));
        chk("core_rdata", core_rdata, ecv ? pend_data : 32'd0);
        chk("ext_rvalid", ext_rvalid, 32'(eev));
        chk("ext_rdata", ext_rdata, eev ? pend_data : 32'd0);

        creq = crd || cwr;
        ewin = !rst && er && (!creq || waited >= LIMIT);
        cwin = !rst && creq && !ewin;
        a    = ewin ? ea : ca;
        wd   = ewin ? ewd : cwd;
        we   = ewin ? ewe : cwr;
        isrd = ewin ? !ewe : (crd && !cwr);
        bad  = 1'b0;
`ifdef DMEM_ARB_ERRCHK_EN
        bad  = (cwin || ewin) && ((a % 4) != 0 || 64'(a) >= (64'd1 << (ADDR_W + 2)));
        chk("err_flag", err_flag, 32'(err_exp));
`endif
        issue = (cwin || ewin) && !bad;
        word  = int'((a >> 2) % (32'd1 << ADDR_W));
        chk("core_stall", core_stall, 32'(!rst && creq && !cwin));
        chk("ext_gnt", ext_gnt, 32'(ewin));
        chk("mem_en", mem_en, 32'(issue));
        chk("mem_we", mem_we, 32'(issue && we));
        chk("mem_addr", 32'(mem_addr), issue ? 32'(word) : 32'd0);
        chk("mem_wdata", mem_wdata, issue ? wd : 32'd0);

        obs_gnt       = ext_gnt;
        last_stall    = !rst && creq && !cwin;
        last_ext_wait = er && !ewin;
        if (rst) begin
            pend_core = 0; pend_ext = 0; waited = 0; err_exp = 0;
        end else begin
            if (issue && we) ref_mem[word] = wd;
            pend_core = cwin && isrd;
            pend_ext  = ewin && isrd;
            pend_data = bad ? 32'd0 : ref_mem[word];
            if (bad) err_exp = 1;
            if (er && !ewin) waited = (waited + 1 > LIMIT) ? LIMIT : waited + 1;
            else             waited = 0;
        end
    endtask

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 15) == 0) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) a = a | (32'($urandom_range(1, 255)) << 20);
        return a;
    endfunction

    initial begin
        bit          r_crd, r_cwr, r_er, r_ewe, r_rst, got;
        logic [31:0] r_ca, r_cwd, r_ea, r_ewd;
        int          waitc, k;
        n_total = 0; n_bad = 0; waited = 0; err_exp = 0;
        pend_core = 0; pend_ext = 0; pend_data = 0;
        last_stall = 0; last_ext_wait = 0; obs_gnt = 0;
        reset = 1; core_memread = 0; core_memwrite = 0; core_addr = 0; core_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;

        cyc(1, 0,0,0,0, 0,0,0,0);
        cyc(1, 1,0,8,0, 1,0,4,0);          // requests during reset: nothing granted

        // Core write addr 17 -> 4, read addr 16, ext idle
        cyc(0, 0,1,17,4, 0,0,0,0);
        cyc(0, 1,0,16,0, 0,0,0,0);
        cyc(0, 0,0,0,0, 0,0,0,0);
`ifndef DMEM_ARB_ERRCHK_EN
        chk("tp_core_rd4", core_rdata, 32'd4);
`endif

        // Preload the 64 words used by random traffic, alternating requesters
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) cyc(0, 0,1,32'(i*4),$urandom, 0,0,0,0);
            else            cyc(0, 0,0,0,0, 1,1,32'(i*4),$urandom);
        end

        // Ext write 0x20 <- 0xDEAD then read back
        cyc(0, 0,0,0,0, 1,1,32'h20,32'hDEAD);
        chk("tp_ext_wr_gnt", 32'(obs_gnt), 32'd1);
        cyc(0, 0,0,0,0, 1,0,32'h20,0);
        cyc(0, 0,0,0,0, 0,0,0,0);
        chk("tp_ext_rd", ext_rdata, 32'hDEAD);

        // Starvation: continuous core reads with ext held
        waitc = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc(0, 1,0,32'(i*4),0, 1,0,32'h40,0);
            if (obs_gnt) got = 1; else waitc++;
        end
        chk("starve_wait", 32'(waitc), 32'(LIMIT));
        chk("starve_stall", 32'(core_stall), 32'd1);
        cyc(0, 1,0,32'h44,0, 0,0,0,0);
        chk("core_resume", 32'(core_stall), 32'd0);

        // Alternating back-to-back reads
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) cyc(0, 1,0,32'(i*8),0, 0,0,0,0);
            else            cyc(0, 0,0,0,0, 1,0,32'(i*8),0);
        end

        // Reset the cycle after a core read issue
        cyc(0, 1,0,32'h8,0, 0,0,0,0);
        cyc(1, 0,0,0,0, 0,0,0,0);
        chk("rst_drop_rv", 32'(core_rvalid), 32'd0);
        cyc(0, 0,0,0,0, 0,0,0,0);
        chk("rst_drop_rv2", 32'(core_rvalid), 32'd0);
        cyc(0, 1,0,32'h20,0, 0,0,0,0);
        cyc(0, 0,0,0,0, 0,0,0,0);
        chk("post_rst_rd", core_rdata, 32'hDEAD);

        // Random traffic obeying the hold rules
        r_crd = 0; r_cwr = 0; r_ca = 0; r_cwd = 0;
        r_er = 0; r_ewe = 0; r_ea = 0; r_ewd = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            if (!last_stall) begin
                k = $urandom_range(0, 7);
                r_crd = (k == 1 || k == 2 || k == 3 || k == 7);
                r_cwr = (k == 4 || k == 5 || k == 7);
                r_ca = raddr(); r_cwd = $urandom;
            end
            if (!last_ext_wait) begin
                r_er = ($urandom_range(0, 2) == 0);
                r_ewe = $urandom_range(0, 1) == 1;
                r_ea = raddr(); r_ewd = $urandom;
            end
            cyc(r_rst, r_crd, r_cwr, r_ca, r_cwd, r_er, r_ewe, r_ea, r_ewd);
        end

`ifdef DMEM_ARB_ERRCHK_EN
        cyc(1, 0,0,0,0, 0,0,0,0);
        cyc(0, 1,0,32'h6,0, 0,0,0,0);
        chk("ec_mem_en", 32'(mem_en), 32'd0);
        cyc(0, 0,0,0,0, 0,0,0,0);
        chk("ec_rvalid", 32'(core_rvalid), 32'd1);
        chk("ec_rdata", core_rdata, 32'd0);
        chk("ec_flag", 32'(err_flag), 32'd1);
        cyc(0, 0,0,0,0, 0,0,0,0);
        chk("ec_flag_hold", 32'(err_flag), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
